// File: rtl/mole_array_ctrl.sv
// Whack-a-mole array controller: per-mole HIDE/RISE/HOLD/FALL lifecycles and saturating BCD score and rise totals.
// Optional build macro MOLE_HIT_RETREAT_EN: a scored hit in RISE or HOLD sends the mole straight to FALL.
module mole_array_ctrl #(
   parameter int NUM_MOLES  = 8,
   parameter int HEIGHT_W   = 5,
   parameter int MAX_HEIGHT = 20,
   parameter int HOLD_TICKS = 4
) (
   input  logic                          clock,
   input  logic                          Mreset_wait,
   input  logic                          rl_tick,
   input  logic                          wait_tick,
   input  logic [NUM_MOLES-1:0]          go,
   input  logic [NUM_MOLES-1:0]          mole_hit,
   output logic [NUM_MOLES-1:0]          hiding,
   output logic [NUM_MOLES*HEIGHT_W-1:0] mole_height,
   output logic [15:0]                   total_score,
   output logic [15:0]                   total_rise,
   output logic                          score_ovf
);
   typedef enum logic [1:0] {HIDE, RISE, HOLD, FALL} state_t;

   localparam logic [HEIGHT_W-1:0] H_ONE    = HEIGHT_W'(1);
   localparam logic [HEIGHT_W-1:0] H_TOP_M1 = HEIGHT_W'(MAX_HEIGHT - 1);
   localparam logic [2:0]          W_LAST   = 3'(HOLD_TICKS - 1);

   logic [NUM_MOLES-1:0][HEIGHT_W-1:0] height;
   logic [NUM_MOLES-1:0]               rise;
   logic [NUM_MOLES-1:0]               scored;

   for (genvar i = 0; i < NUM_MOLES; i++) begin : g_mole
      state_t              state;
      logic [HEIGHT_W-1:0] hgt;
      logic [2:0]          wait_cnt;
      logic                hide_r;
      logic                hit_done;
      logic                hit_q;
      logic                hit_qq;
      logic                retreat;

      // Hit is judged against the state held at the edge that sees the registered rising edge.
      assign rise[i]   = (state == HIDE) && go[i];
      assign scored[i] = hit_q && !hit_qq && (state != HIDE) && !hit_done;
`ifdef MOLE_HIT_RETREAT_EN
      assign retreat   = scored[i] && ((state == RISE) || (state == HOLD));
`else
      assign retreat   = 1'b0;
`endif
      assign height[i] = hgt;
      assign hiding[i] = hide_r;

      always_ff @(posedge clock or posedge Mreset_wait) begin
         if (Mreset_wait) begin
            state    <= HIDE;
            hgt      <= '0;
            wait_cnt <= '0;
            hide_r   <= 1'b1;
            hit_done <= 1'b0;
            hit_q    <= 1'b0;
            hit_qq   <= 1'b0;
         end else begin
            hit_q  <= mole_hit[i];
            hit_qq <= hit_q;
            if (scored[i]) hit_done <= 1'b1;
            case (state)
               HIDE: begin
                  if (go[i]) begin
                     state    <= RISE;
                     hide_r   <= 1'b0;
                     hit_done <= 1'b0;
                  end
               end
               RISE: begin
                  if (retreat) begin
                     state <= FALL;
                  end else if (rl_tick) begin
                     hgt <= hgt + H_ONE;
                     if (hgt == H_TOP_M1) begin
                        state    <= HOLD;
                        wait_cnt <= '0;
                     end
                  end
               end
               HOLD: begin
                  if (retreat) begin
                     state <= FALL;
                  end else if (wait_tick) begin
                     if (wait_cnt == W_LAST) state <= FALL;
                     else                    wait_cnt <= wait_cnt + 3'd1;
                  end
               end
               FALL: begin
                  // A retreat from RISE can start FALL at height 0, so clamp rather than wrap.
                  if (rl_tick) begin
                     if (hgt <= H_ONE) begin
                        hgt    <= '0;
                        state  <= HIDE;
                        hide_r <= 1'b1;
                     end else begin
                        hgt <= hgt - H_ONE;
                     end
                  end
               end
               default: state <= HIDE;
            endcase
         end
      end
   end

   assign mole_height = height;

   function automatic logic [3:0] popcnt(input logic [NUM_MOLES-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int k = 0; k < NUM_MOLES; k++) c = c + {3'b000, v[k]};
      return c;
   endfunction

   // Returns {decimal carry out of the thousands digit, raw 4-digit BCD sum}.
   function automatic logic [16:0] bcd_add(input logic [15:0] tot, input logic [3:0] inc);
      logic [4:0]  d;
      logic [3:0]  cy;
      logic [15:0] s;
      cy = inc;
      s  = '0;
      for (int k = 0; k < 4; k++) begin
         d = {1'b0, tot[4*k +: 4]} + {1'b0, cy};
         if (d > 5'd9) begin
            s[4*k +: 4] = 4'(d - 5'd10);
            cy          = 4'd1;
         end else begin
            s[4*k +: 4] = d[3:0];
            cy          = 4'd0;
         end
      end
      return {cy[0], s};
   endfunction

   logic [16:0] score_nx;
   logic [16:0] rise_nx;

   always_comb begin
      score_nx = bcd_add(total_score, popcnt(scored));
      rise_nx  = bcd_add(total_rise, popcnt(rise));
   end

   always_ff @(posedge clock or posedge Mreset_wait) begin
      if (Mreset_wait) begin
         total_score <= 16'h0000;
         total_rise  <= 16'h0000;
         score_ovf   <= 1'b0;
      end else begin
         total_score <= score_nx[16] ? 16'h9999 : score_nx[15:0];
         total_rise  <= rise_nx[16]  ? 16'h9999 : rise_nx[15:0];
         if (score_nx[16]) score_ovf <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mole_array_ctrl.sv
// Bench for mole_array_ctrl: integer-level lifecycle/score model checked every cycle, plus directed literal checks.
module tb_mole_array_ctrl;
   localparam int NM = 8;
   localparam int HW = 5;
   localparam int MH = 20;
   localparam int HT = 4;
`ifdef MOLE_HIT_RETREAT_EN
   localparam bit RETREAT = 1'b1;
`else
   localparam bit RETREAT = 1'b0;
`endif
   localparam int P_HIDE = 0, P_RISE = 1, P_HOLD = 2, P_FALL = 3;

   logic              clock = 1'b0;
   logic              Mreset_wait = 1'b0;
   logic              rl_tick = 1'b0;
   logic              wait_tick = 1'b0;
   logic [NM-1:0]     go = '0;
   logic [NM-1:0]     mole_hit = '0;
   logic [NM-1:0]     hiding;
   logic [NM*HW-1:0]  mole_height;
   logic [15:0]       total_score;
   logic [15:0]       total_rise;
   logic              score_ovf;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   mole_array_ctrl #(.NUM_MOLES(NM), .HEIGHT_W(HW), .MAX_HEIGHT(MH), .HOLD_TICKS(HT)) dut (
      .clock(clock), .Mreset_wait(Mreset_wait), .rl_tick(rl_tick), .wait_tick(wait_tick),
      .go(go), .mole_hit(mole_hit), .hiding(hiding), .mole_height(mole_height),
      .total_score(total_score), .total_rise(total_rise), .score_ovf(score_ovf));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase per mole, heights and totals as plain integers.
   int ph[NM], ht[NM], wt[NM];
   bit done[NM], r1[NM], r2[NM];
   int m_score, m_rise;
   bit m_ovf;
   bit chk_en = 1'b0;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NM; i++) begin
         ph[i] = P_HIDE; ht[i] = 0; wt[i] = 0; done[i] = 0; r1[i] = 0; r2[i] = 0;
      end
      m_score = 0; m_rise = 0; m_ovf = 0;
   endtask

   task automatic model_step();
      int sc, rc;
      bit edge_h, hit;
      sc = 0; rc = 0;
      for (int i = 0; i < NM; i++) begin
         edge_h = r1[i] && !r2[i];
         hit = edge_h && (ph[i] != P_HIDE) && !done[i];
         if (hit) begin sc++; done[i] = 1; end
         case (ph[i])
            P_HIDE: if (go[i]) begin ph[i] = P_RISE; done[i] = 0; rc++; end
            P_RISE: begin
               if (RETREAT && hit) ph[i] = P_FALL;
               else if (rl_tick) begin
                  ht[i]++;
                  if (ht[i] == MH) begin ph[i] = P_HOLD; wt[i] = 0; end
               end
            end
            P_HOLD: begin
               if (RETREAT && hit) ph[i] = P_FALL;
               else if (wait_tick) begin
                  wt[i]++;
                  if (wt[i] == HT) ph[i] = P_FALL;
               end
            end
            default: begin
               if (rl_tick) begin
                  ht[i] = (ht[i] > 0) ? ht[i] - 1 : 0;
                  if (ht[i] == 0) ph[i] = P_HIDE;
               end
            end
         endcase
         r2[i] = r1[i];
         r1[i] = mole_hit[i];
      end
      m_score += sc;
      if (m_score > 9999) begin m_score = 9999; m_ovf = 1; end
      m_rise = (m_rise + rc > 9999) ? 9999 : m_rise + rc;
   endtask

   always @(posedge clock or posedge Mreset_wait) begin
      if (Mreset_wait) model_reset();
      else             model_step();
   end

   logic [NM-1:0]    eh;
   logic [NM*HW-1:0] eht;
   always @(negedge clock) begin
      if (chk_en) begin
         for (int i = 0; i < NM; i++) begin
            eh[i] = (ph[i] == P_HIDE);
            eht[i*HW +: HW] = HW'(ht[i]);
         end
         chk("hiding", 64'(hiding), 64'(eh));
         chk("height", 64'(mole_height), 64'(eht));
         chk("score", 64'(total_score), 64'(to_bcd(m_score)));
         chk("rise", 64'(total_rise), 64'(to_bcd(m_rise)));
         chk("ovf", 64'(score_ovf), 64'(m_ovf));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clock); #2; end
   endtask

   task automatic do_reset();
      Mreset_wait = 1'b1; step(1); Mreset_wait = 1'b0;
   endtask

   task automatic round(input logic [NM-1:0] mask);
      go = mask; step(1); go = '0;
      mole_hit = mask; step(1); mole_hit = '0;
      step(43);
   endtask

   int mx;

   initial begin
      model_reset();
      Mreset_wait = 1'b1; step(2); Mreset_wait = 1'b0;
      chk_en = 1'b1;
      chk("rst_hiding", 64'(hiding), 64'hFF);
      chk("rst_height", 64'(mole_height), 64'h0);
      chk("rst_score", 64'(total_score), 64'h0);
      chk("rst_rise", 64'(total_rise), 64'h0);
      chk("rst_ovf", 64'(score_ovf), 64'h0);

      // Full lifecycle of mole 0 with both ticks held high.
      rl_tick = 1'b1; wait_tick = 1'b1;
      go = 8'h01; step(1); go = '0;
      chk("life_hiding0", 64'(hiding), 64'hFE);
      step(20); chk("life_top", 64'(mole_height[0 +: HW]), 64'd20);
      step(4);  chk("life_hold_end", 64'(mole_height[0 +: HW]), 64'd20);
      step(1);  chk("life_fall1", 64'(mole_height[0 +: HW]), 64'd19);
      step(19);
      chk("life_h0", 64'(mole_height[0 +: HW]), 64'd0);
      chk("life_hidden", 64'(hiding), 64'hFF);
      chk("life_rise", 64'(total_rise), 64'h0001);

      // Held level and later edges within one rise score once.
      do_reset();
      rl_tick = 1'b0; wait_tick = 1'b0;
      go = 8'h08; step(1); go = '0;
      mole_hit = 8'h08; step(10);
      mole_hit = '0; step(1); mole_hit = 8'h08; step(1);
      mole_hit = '0; step(1); mole_hit = 8'h08; step(1);
      mole_hit = '0; step(2);
      chk("once_score", 64'(total_score), 64'h0001);

      // Decimal carry ripple, then saturation.
      do_reset();
      rl_tick = 1'b1; wait_tick = 1'b1;
      repeat (124) round(8'hFF);
      round(8'h3F);
      chk("pre_998", 64'(total_score), 64'h0998);
      go = 8'h07; step(1); go = '0;
      mole_hit = 8'h07; step(1); mole_hit = '0; step(1);
      chk("carry_1001", 64'(total_score), 64'h1001);
      step(42);
      repeat (1124) round(8'hFF);
      round(8'h1F);
      chk("pre_9998", 64'(total_score), 64'h9998);
      chk("pre_ovf", 64'(score_ovf), 64'h0);
      go = 8'h07; step(1); go = '0;
      mole_hit = 8'h07; step(1); mole_hit = '0; step(1);
      chk("sat_9999", 64'(total_score), 64'h9999);
      chk("sat_ovf", 64'(score_ovf), 64'h1);
      step(42);
      chk("rise_sat", 64'(total_rise), 64'h9999);

      // Asynchronous reset mid-RISE.
      go = 8'h20; step(1); go = '0;
      step(12);
      chk("mid_h12", 64'(mole_height[5*HW +: HW]), 64'd12);
      #1 Mreset_wait = 1'b1; #1;
      chk("arst_height", 64'(mole_height), 64'h0);
      chk("arst_hiding", 64'(hiding), 64'hFF);
      chk("arst_score", 64'(total_score), 64'h0);
      chk("arst_rise", 64'(total_rise), 64'h0);
      chk("arst_ovf", 64'(score_ovf), 64'h0);
      step(1); Mreset_wait = 1'b0;

      // Hit mole 1 at height 10 during RISE.
      go = 8'h02; step(1); go = '0;
      step(9);
      chk("hit_h9", 64'(mole_height[HW +: HW]), 64'd9);
      mole_hit = 8'h02; step(1); mole_hit = '0;
      mx = 0;
      for (int k = 0; k < 60; k++) begin
         if (int'(mole_height[HW +: HW]) > mx) mx = int'(mole_height[HW +: HW]);
         step(1);
      end
      chk("hit_peak", 64'(mx), 64'(RETREAT ? 10 : 20));
      chk("hit_hidden", 64'(hiding), 64'hFF);
      chk("hit_score", 64'(total_score), 64'h0001);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rl_tick   = ($urandom_range(0, 3) != 0);
         wait_tick = $urandom_range(0, 1) == 1;
         for (int i = 0; i < NM; i++) begin
            go[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) mole_hit[i] = ~mole_hit[i];
         end
         if ($urandom_range(0, 999) == 0) begin
            Mreset_wait = 1'b1; step(1); Mreset_wait = 1'b0;
         end else begin
            step(1);
         end
      end
      go = '0; mole_hit = '0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
